// File: rtl/rn_result_tx.sv
// rn_result_tx
// ------------
// Transmit side of the RN diagnostic path. A start request reads N 16-bit
// result samples from the RN result RAM (1-cycle read latency). It packs
// them in pairs, low sample first, into 32-bit words. Each word is written
// into the FPGA-to-host FIFO that feeds the rn_diag_result device.
//
// Optional feature (macro RN_TX_CHECKSUM_EN):
//   When defined, a running 16-bit sum of the samples is kept. After the
//   last data word, one trailer word {16'hA5A5, sum} is written.
//
// Ports:
//   iClk        bus clock
//   iReset      synchronous active-high reset
//   iStart      one-cycle start request, honoured only while idle
//   i8Length    sample count N, latched on start (0 means 2^ADDR_W)
//   o8RamAddr   RAM read address
//   oRamReadEna RAM read enable
//   i16RamData  RAM read data, valid the cycle after oRamReadEna
//   oFifoWrEn   FIFO write strobe (never asserted while iFifoFull)
//   o32FifoData FIFO write data
//   iFifoFull   FIFO full flag
//   oBusy       high while reading, packing or writing
//   oDone       one-cycle completion pulse
module rn_result_tx #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = {ADDR_W{1'b0}},
    parameter logic [15:0]        PAD_VALUE = 16'h0000
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] i8Length,
    output logic [ADDR_W-1:0] o8RamAddr,
    output logic              oRamReadEna,
    input  logic [15:0]       i16RamData,
    output logic              oFifoWrEn,
    output logic [31:0]       o32FifoData,
    input  logic              iFifoFull,
    output logic              oBusy,
    output logic              oDone
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_WR   = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Modulo-2^16 accumulate used for the trailer checksum.
    function automatic logic [15:0] sum16(input logic [15:0] acc, input logic [15:0] val);
        sum16 = acc + val;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;      // one extra bit so 2^ADDR_W fits
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     cnt_inc_s;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                half_q, half_d;    // 0: low half next, 1: high half next
    logic [31:0]         word_q, word_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef RN_TX_CHECKSUM_EN
    logic [15:0]         sum_q, sum_d;
`endif

    assign cnt_inc_s = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state, datapath and next registered-output computation.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        half_d  = half_q;
        word_d  = word_q;
`ifdef RN_TX_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_RD;
                    if (i8Length == {ADDR_W{1'b0}}) begin
                        len_d = {1'b1, {ADDR_W{1'b0}}};
                    end else begin
                        len_d = {1'b0, i8Length};
                    end
                    cnt_d  = {(ADDR_W+1){1'b0}};
                    addr_d = BASE_ADDR;
                    half_d = 1'b0;
`ifdef RN_TX_CHECKSUM_EN
                    sum_d  = 16'h0000;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_LAT;
            end
            S_LAT: begin
                addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                cnt_d  = cnt_inc_s;
                half_d = ~half_q;
`ifdef RN_TX_CHECKSUM_EN
                sum_d  = sum16(sum_q, i16RamData);
`endif
                if (half_q) begin
                    word_d[31:16] = i16RamData;
                    state_d       = S_WR;
                end else begin
                    word_d[15:0] = i16RamData;
                    if (cnt_inc_s == len_q) begin
                        // Odd count: the high half will never be filled.
                        word_d[31:16] = PAD_VALUE;
                        state_d       = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                if (!iFifoFull) begin
                    if (cnt_q == len_q) begin
`ifdef RN_TX_CHECKSUM_EN
                        state_d = S_CHK;
                        word_d  = {16'hA5A5, sum_q};
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_RD;
                        half_d  = 1'b0;
                    end
                end else begin
                    state_d = S_WR;
                end
            end
            S_CHK: begin
`ifdef RN_TX_CHECKSUM_EN
                if (!iFifoFull) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CHK;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        rd_en_d = (state_d == S_RD);
        busy_d  = (state_d == S_RD) || (state_d == S_LAT) ||
                  (state_d == S_WR) || (state_d == S_CHK);
        done_d  = (state_d == S_DONE);
        if (state_d == S_RD) begin
            ram_addr_d = addr_d;
        end else begin
            ram_addr_d = ram_addr_q;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            len_q      <= {(ADDR_W+1){1'b0}};
            cnt_q      <= {(ADDR_W+1){1'b0}};
            addr_q     <= BASE_ADDR;
            half_q     <= 1'b0;
            word_q     <= 32'h0000_0000;
            rd_en_q    <= 1'b0;
            ram_addr_q <= BASE_ADDR;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef RN_TX_CHECKSUM_EN
            sum_q      <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            half_q     <= half_d;
            word_q     <= word_d;
            rd_en_q    <= rd_en_d;
            ram_addr_q <= ram_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef RN_TX_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // The write strobe must react to iFifoFull in the same cycle, so it is
    // decoded from the registered state rather than registered itself.
    assign oFifoWrEn   = ((state_q == S_WR) || (state_q == S_CHK)) && !iFifoFull && !iReset;
    assign o32FifoData = word_q;
    assign o8RamAddr   = ram_addr_q;
    assign oRamReadEna = rd_en_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;

endmodule

// File: tb/tb_rn_result_tx.sv
module tb_rn_result_tx;

    localparam logic [7:0]  BASE = 8'hF0;
    localparam logic [15:0] PAD  = 16'h0000;
`ifdef RN_TX_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, rd_en, wr_en, full, busy, done;
    logic [7:0]  len, addr;
    logic [15:0] rdata;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    rn_result_tx #(.ADDR_W(8), .BASE_ADDR(BASE), .PAD_VALUE(PAD)) dut (
        .iClk(clk), .iReset(rst), .iStart(start), .i8Length(len),
        .o8RamAddr(addr), .oRamReadEna(rd_en), .i16RamData(rdata),
        .oFifoWrEn(wr_en), .o32FifoData(wdata), .iFifoFull(full),
        .oBusy(busy), .oDone(done)
    );

    // Behavioural RAM with one cycle of read latency.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (rd_en) rdata <= mem[addr];
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_words [$];
    logic [31:0] got_words [$];
    logic [7:0]  exp_addrs [$];
    bit          op_active = 1'b0;
    int          busy_cnt, full_cnt, min_cycles;
    logic [7:0]  last_rd_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                check("wr_while_full", 32'(full), 32'd0);
                if (exp_words.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_write: got %h expected none", wdata);
                end else begin
                    check("fifo_word", wdata, exp_words.pop_front());
                end
                got_words.push_back(wdata);
            end
            if (rd_en) begin
                last_rd_addr = addr;
                if (exp_addrs.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_read: got %h expected none", addr);
                end else begin
                    check("ram_addr", 32'(addr), 32'(exp_addrs.pop_front()));
                end
            end
            if (op_active) begin
                if (busy) busy_cnt++;
                if (busy && full) full_cnt++;
                if (done) begin
                    check("words_left", 32'(exp_words.size()), 32'd0);
                    check("reads_left", 32'(exp_addrs.size()), 32'd0);
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("busy_min", 32'(busy_cnt >= min_cycles), 32'd1);
                    check("busy_max", 32'(busy_cnt <= min_cycles + full_cnt), 32'd1);
                    op_active = 1'b0;
                end
            end else begin
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_done", 32'(done), 32'd0);
            end
        end
    end

    // Launch one transfer and build the expected words/addresses from the RAM image.
    task automatic start_op(input logic [7:0] l);
        int n;
        logic [15:0] lo, hi, sum;
        logic [7:0]  a;
        n = (l == 8'd0) ? 256 : int'(l);
        exp_words.delete(); exp_addrs.delete(); got_words.delete();
        sum = 16'h0000;
        for (int i = 0; i < n; i += 2) begin
            a  = BASE + 8'(i);
            lo = mem[a];
            hi = (i + 1 < n) ? mem[8'(a + 8'd1)] : PAD;
            exp_words.push_back({hi, lo});
        end
        for (int i = 0; i < n; i++) begin
            exp_addrs.push_back(BASE + 8'(i));
            sum = sum + mem[BASE + 8'(i)];
        end
        if (CHK == 1) exp_words.push_back({16'hA5A5, sum});
        busy_cnt   = 0;
        full_cnt   = 0;
        min_cycles = 2 * n + (n + 1) / 2 + CHK;
        op_active  = 1'b1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        op_active = 1'b0;
        exp_words.delete(); exp_addrs.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_full);
        int k;
        k = 0;
        while (op_active && k < budget) begin
            full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
            k++;
        end
        full = 1'b0;
        if (op_active) begin
            total++; bad++;
            $display("FAIL done_timeout: got no oDone expected within %0d cycles", budget);
            do_reset();
        end
    endtask

    task automatic wait_words(input int cnt, input int budget);
        int k;
        k = 0;
        while (got_words.size() < cnt && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("words_reached", 32'(got_words.size() >= cnt), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0; full = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_addr", 32'(addr), 32'(BASE));
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_data", wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // N=4 plain pairs
        mem[BASE] = 16'h1111; mem[BASE+8'd1] = 16'h2222;
        mem[BASE+8'd2] = 16'h3333; mem[BASE+8'd3] = 16'h4444;
        start_op(8'd4);
        wait_done(200, 1'b0);
        check("n4_count", 32'(got_words.size()), 32'(2 + CHK));
        check("n4_w0", got_words[0], 32'h2222_1111);
        check("n4_w1", got_words[1], 32'h4444_3333);
        check("n4_cycles", 32'(busy_cnt), 32'(10 + CHK));
        repeat (3) @(posedge clk);
        #1;
        check("n4_busy_after", 32'(busy), 32'd0);

        // N=3 odd count, padded high half
        mem[BASE] = 16'hAAAA; mem[BASE+8'd1] = 16'hBBBB; mem[BASE+8'd2] = 16'hCCCC;
        start_op(8'd3);
        wait_done(200, 1'b0);
        check("n3_count", 32'(got_words.size()), 32'(2 + CHK));
        check("n3_w0", got_words[0], 32'hBBBB_AAAA);
        check("n3_w1", got_words[1], 32'h0000_CCCC);

        // N=2 with FIFO full for the first 10 cycles of WR
        mem[BASE] = 16'h1111; mem[BASE+8'd1] = 16'h2222;
        start_op(8'd2);
        full = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("stall_no_write", 32'(got_words.size()), 32'd0);
        full = 1'b0;
        wait_done(200, 1'b0);
        check("stall_count", 32'(got_words.size()), 32'(1 + CHK));
        check("stall_w0", got_words[0], 32'h2222_1111);
        check("stall_cycles", 32'(busy_cnt), 32'(15 + CHK));

        // N=0 means 256 samples, address wraps from the base
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        start_op(8'd0);
        wait_done(2000, 1'b0);
        check("wrap_count", 32'(got_words.size()), 32'(128 + CHK));
        check("wrap_last_addr", 32'(last_rd_addr), 32'h0000_00EF);

        // Start while busy ignored, reset mid-stream aborts, fresh start completes
        start_op(8'd8);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_words(2, 200);
        do_reset();
        repeat (30) @(posedge clk);
        #1;
        check("abort_count", 32'(got_words.size()), 32'd2);
        start_op(8'd8);
        wait_done(300, 1'b0);
        check("fresh_count", 32'(got_words.size()), 32'(4 + CHK));

        // Start presented during the DONE cycle is ignored
        start_op(8'd1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (done) break;
        end
        start = 1'b1; len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("n1_count", 32'(got_words.size()), 32'(1 + CHK));
        repeat (12) @(posedge clk);
        #1;
        check("done_start_ignored", 32'(busy), 32'd0);

`ifdef RN_TX_CHECKSUM_EN
        mem[BASE] = 16'hFFFF; mem[BASE+8'd1] = 16'h0002;
        start_op(8'd2);
        wait_done(200, 1'b0);
        check("chk_count", 32'(got_words.size()), 32'd2);
        check("chk_w0", got_words[0], 32'h0002_FFFF);
        check("chk_trailer", got_words[1], 32'hA5A5_0001);
`endif

        // Randomized transfers with random FIFO back-pressure
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            start_op(8'($urandom_range(0, 255)));
            wait_done(4000, 1'b1);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rn_result_tx.md
Name: rn_result_tx

Overview:
- Transmit-side counterpart to the RN diagnostic receive path.
- On a start pulse, reads N 16-bit result samples from the RN result RAM (1-cycle read latency).
- Packs samples in pairs into 32-bit words and writes them into the FPGA-to-host FIFO (fifo_RN_FPGA_Host) that feeds /dev/xillybus_rn_diag_result.
- Respects FIFO full and reports busy/done to the RN state machine.

Parameters:
- ADDR_W, 8: RAM address width; maximum sample count is 2^ADDR_W.
- BASE_ADDR, 0: first RAM address read.
- PAD_VALUE, 16'h0000: fill value for the upper half of the final word when N is odd.

Ports:
- iClk  in  1  bus clock (bus_clk).
- iReset  in  1  synchronous, active-high reset (user_w_fpga_reset_open).
- iStart  in  1  one-cycle start request; ignored unless idle.
- i8Length  in  ADDR_W  sample count N, latched on start; 0 means 2^ADDR_W.
- o8RamAddr  out  ADDR_W  RAM read address.
- oRamReadEna  out  1  RAM read enable.
- i16RamData  in  16  RAM data, valid the cycle after oRamReadEna.
- oFifoWrEn  out  1  FIFO write strobe.
- o32FifoData  out  32  FIFO write data.
- iFifoFull  in  1  FIFO full flag.
- oBusy  out  1  high from the cycle after an accepted start until the DONE state.
- oDone  out  1  one-cycle completion pulse.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, on iClk.
- Reset values: o8RamAddr=BASE_ADDR, oRamReadEna=0, oFifoWrEn=0, o32FifoData=0, oBusy=0, oDone=0. FSM returns to IDLE, counters clear.
- IDLE:
  - On iStart: latch N (0 maps to 2^ADDR_W), addr=BASE_ADDR, sample count=0, half=LOW; go to RD.
- RD:
  - oRamReadEna=1, o8RamAddr=addr for exactly one cycle; go to LAT.
- LAT:
  - Capture i16RamData into the current half: LOW → word[15:0], HIGH → word[31:16].
  - Increment sample count and addr; toggle half.
  - If the HIGH half was just filled, or count==N: go to WR, filling word[31:16] with PAD_VALUE if still empty.
  - Otherwise go to RD.
- WR:
  - o32FifoData holds the packed word.
  - oFifoWrEn=1 for one cycle, only in a cycle where iFifoFull=0. While full, stall with oFifoWrEn=0 and data held.
  - After the write: count==N → DONE, else RD with half=LOW.
- DONE:
  - oDone=1 for one cycle; go to IDLE.
- oBusy=1 in RD, LAT and WR.
- Throughput, no stalls:
  - Each sample costs 2 cycles (RD+LAT); each write costs 1 cycle.
  - Full pair = 5 cycles. N=2: iStart at cycle 0, write at cycle 5, oDone at cycle 6.
- Word count = ceil(N/2).
- Address increments modulo 2^ADDR_W. With BASE_ADDR≠0 and N=2^ADDR_W, the address wraps, and every address is read exactly once.
- iStart while not in IDLE (including DONE): ignored, no effect.
- iFifoFull asserted in the same cycle WR is entered: no write that cycle.
- Reset mid-operation (any state): abort immediately. No further RAM reads or FIFO writes; a partially packed word is discarded.
- oFifoWrEn is never asserted while iFifoFull=1.

Optional Feature:
- Macro: RN_TX_CHECKSUM_EN.
- Defined:
  - Keep a running 16-bit sum (mod 2^16) of all N samples, cleared on start. PAD_VALUE is not included in the sum.
  - After the last data word, enter state CHK and write one trailer word {16'hA5A5, sum}, under the same full-stall rule as WR; then go to DONE.
  - Word count becomes ceil(N/2)+1.
- Not defined:
  - No CHK state and no trailer; the last data word goes directly to DONE.

Test Plan:
- N=4, RAM[0..3]=0x1111,0x2222,0x3333,0x4444, FIFO never full → exactly two writes: 0x22221111, 0x44443333; oDone one cycle later; oBusy low afterwards.
- N=3, PAD_VALUE=0, RAM[0..2]=0xAAAA,0xBBBB,0xCCCC → writes 0xBBBBAAAA, 0x0000CCCC.
- N=2 with iFifoFull held high for 10 cycles on WR entry → oFifoWrEn stays 0 for those 10 cycles; 0x22221111 is written on the first non-full cycle; no duplicate write.
- i8Length=0 with BASE_ADDR=0xF0 → 256 reads, address wraps 0xFF→0x00 and ends at 0xEF; 128 writes.
- Reset asserted mid-stream of N=8 after 2 words, then a second iStart during busy → no further writes after reset; the start during busy is ignored; a fresh start after reset produces the full 4 words.
- With RN_TX_CHECKSUM_EN, N=2, samples 0xFFFF,0x0002 → writes 0x0002FFFF, then 0xA5A50001.
